// File: rtl/c66x_power_supervisor.sv
// C66x power-sequencer initiator: POR hold, start timeout, heartbeat watchdog, retry backoff and fault lockout.
// Outputs are registered one cycle behind the FSM state; seq_up/dsp_heartbeat pass a 2-flop synchroniser; no backpressure.
module c66x_power_supervisor #(
  parameter int POR_DELAY     = 100,
  parameter int START_TIMEOUT = 1000,
  parameter int BOOT_GRACE    = 20000,
  parameter int WDT_TIMEOUT   = 5000,
  parameter int MIN_OFF       = 300,
  parameter int BACKOFF_BASE  = 500,
  parameter int MAX_RETRIES   = 3,
  parameter int STABLE_TIME   = 10000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       power_request,
  input  logic       seq_up,
  input  logic       dsp_heartbeat,
  output logic       enable,
  output logic       running,
  output logic       lockout,
  output logic [1:0] fault_code,
  output logic [1:0] retry_count
);

  typedef enum logic [2:0] {
    POR_HOLD = 3'd0,
    OFF      = 3'd1,
    STARTING = 3'd2,
    RUNNING  = 3'd3,
    STOPPING = 3'd4,
    BACKOFF  = 3'd5,
    LOCKOUT  = 3'd6
  } state_t;

  localparam logic [1:0]  FAULT_NONE   = 2'd0;
  localparam logic [1:0]  FAULT_START  = 2'd1;
  localparam logic [1:0]  FAULT_DROP   = 2'd2;
  localparam logic [1:0]  FAULT_WDT    = 2'd3;
  localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);
  localparam logic [15:0] POR_LAST     = 16'(POR_DELAY - 1);
  localparam logic [15:0] START_LAST   = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] GRACE_LAST   = 16'(BOOT_GRACE - 1);
  localparam logic [15:0] WDT_LAST     = 16'(WDT_TIMEOUT - 1);
  localparam logic [15:0] MIN_OFF_LAST = 16'(MIN_OFF - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_TIME - 1);
  localparam logic [15:0] BACKOFF_16   = 16'(BACKOFF_BASE);

  state_t      state, state_next;
  logic [15:0] timer;
  logic [15:0] wdt;
  logic        armed;
  logic [1:0]  fault_q, fault_next;
  logic [1:0]  retry_q, retry_next;
  logic        pend, pend_next;

  logic        seq_meta, seq_sync;
  logic        hb_meta, hb_sync, hb_prev;
  logic        hb_edge;
  logic [15:0] backoff_last;
  logic [15:0] wdt_last;
  logic        wdt_expired;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      seq_meta <= 1'b0;
      seq_sync <= 1'b0;
      hb_meta  <= 1'b0;
      hb_sync  <= 1'b0;
      hb_prev  <= 1'b0;
    end else begin
      seq_meta <= seq_up;
      seq_sync <= seq_meta;
      hb_meta  <= dsp_heartbeat;
      hb_sync  <= hb_meta;
      hb_prev  <= hb_sync;
    end
  end

  assign hb_edge      = hb_sync & ~hb_prev;
  assign backoff_last = (BACKOFF_16 << retry_q) - 16'd1;
  assign wdt_last     = armed ? WDT_LAST : GRACE_LAST;
  // A heartbeat landing on the expiry cycle rescues the DSP.
  assign wdt_expired  = !hb_edge && (wdt >= wdt_last);

  always_comb begin
    state_next = state;
    fault_next = fault_q;
    retry_next = retry_q;
    pend_next  = pend;
    case (state)
      POR_HOLD: begin
        if (timer == POR_LAST) state_next = OFF;
      end
      OFF: begin
        if (power_request) state_next = STARTING;
      end
      STARTING: begin
        if (!power_request) begin
          state_next = STOPPING;
          pend_next  = 1'b0;
        end else if (seq_sync) begin
          state_next = RUNNING;
        end else if (timer == START_LAST) begin
          state_next = STOPPING;
          fault_next = FAULT_START;
          pend_next  = 1'b1;
        end
      end
      RUNNING: begin
        // Faults outrank a simultaneous power_request drop.
        if (!seq_sync) begin
          state_next = STOPPING;
          fault_next = FAULT_DROP;
          pend_next  = 1'b1;
        end else if (wdt_expired) begin
          state_next = STOPPING;
          fault_next = FAULT_WDT;
          pend_next  = 1'b1;
        end else if (!power_request) begin
          state_next = STOPPING;
          pend_next  = 1'b0;
        end else if (timer == STABLE_LAST) begin
          retry_next = 2'd0;
          fault_next = FAULT_NONE;
        end
      end
      STOPPING: begin
        if (timer == MIN_OFF_LAST) begin
          if (!pend)                     state_next = OFF;
          else if (retry_q == RETRY_MAX) state_next = LOCKOUT;
          else                           state_next = BACKOFF;
        end
      end
      BACKOFF: begin
        if (timer == backoff_last) begin
          if (retry_q != 2'd3) retry_next = retry_q + 2'd1;
          state_next = power_request ? STARTING : OFF;
        end
      end
      LOCKOUT: begin
        if (!power_request) begin
          state_next = OFF;
          retry_next = 2'd0;
          fault_next = FAULT_NONE;
        end
      end
      default: begin
        state_next = STOPPING;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= POR_HOLD;
      timer   <= 16'd0;
      wdt     <= 16'd0;
      armed   <= 1'b0;
      fault_q <= FAULT_NONE;
      retry_q <= 2'd0;
      pend    <= 1'b0;
    end else begin
      state   <= state_next;
      fault_q <= fault_next;
      retry_q <= retry_next;
      pend    <= pend_next;
      if (state_next != state)  timer <= 16'd0;
      else if (timer != 16'hFFFF) timer <= timer + 16'd1;
      // Watchdog only runs while RUNNING; it arms on the first heartbeat edge.
      if (state != RUNNING || hb_edge) wdt <= 16'd0;
      else if (wdt != 16'hFFFF)        wdt <= wdt + 16'd1;
      armed <= (state == RUNNING) && (armed || hb_edge);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      enable      <= 1'b0;
      running     <= 1'b0;
      lockout     <= 1'b0;
      fault_code  <= FAULT_NONE;
      retry_count <= 2'd0;
    end else begin
      enable      <= (state == STARTING) || (state == RUNNING);
      running     <= (state == RUNNING);
      lockout     <= (state == LOCKOUT);
      fault_code  <= fault_q;
      retry_count <= retry_q;
    end
  end

endmodule

// File: tb/tb_c66x_power_supervisor.sv
// Bench for c66x_power_supervisor: expected outputs are queued with the cycle they fall due and compared on the falling edge.
module tb_c66x_power_supervisor;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       power_request;
  logic       seq_up;
  logic       dsp_heartbeat;
  logic       enable, running, lockout;
  logic [1:0] fault_code, retry_count;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    string       name;
    int unsigned due;
    logic        en, run, lk;
    logic [1:0]  fc, rc;
  } exp_t;

  typedef struct {
    string       name;
    int unsigned at;
    logic        req, seq;
    logic        en, run, lk;
    logic [1:0]  fc, rc;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  c66x_power_supervisor dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .power_request (power_request),
    .seq_up        (seq_up),
    .dsp_heartbeat (dsp_heartbeat),
    .enable        (enable),
    .running       (running),
    .lockout       (lockout),
    .fault_code    (fault_code),
    .retry_count   (retry_count)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_checks++;
        if ({enable, running, lockout, fault_code, retry_count} !==
            {sb[i].en, sb[i].run, sb[i].lk, sb[i].fc, sb[i].rc}) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got en=%b run=%b lk=%b fc=%0d rc=%0d, want en=%b run=%b lk=%b fc=%0d rc=%0d",
                   sb[i].name, cyc, enable, running, lockout, fault_code, retry_count,
                   sb[i].en, sb[i].run, sb[i].lk, sb[i].fc, sb[i].rc);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: due at cyc %0d, not compared (now %0d)", sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input string nm, input int unsigned due, input logic en, run, lk,
                           input logic [1:0] fc, rc);
    exp_t e;
    e.name = nm; e.due = due; e.en = en; e.run = run; e.lk = lk; e.fc = fc; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic step_to(input int unsigned target);
    while (cyc < target) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic do_reset(input logic req, input logic seq, output int unsigned base);
    @(posedge sysclk);
    #1;
    reset = 1'b1; power_request = req; seq_up = seq; dsp_heartbeat = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic add_vec(input string nm, input int unsigned at, input logic req, seq, en, run, lk,
                         input logic [1:0] fc, rc);
    vec_t v;
    v.name = nm; v.at = at; v.req = req; v.seq = seq;
    v.en = en; v.run = run; v.lk = lk; v.fc = fc; v.rc = rc;
    vt.push_back(v);
  endtask

  task automatic run_vectors(input int unsigned base);
    foreach (vt[i]) begin
      step_to(base + vt[i].at);
      power_request = vt[i].req;
      seq_up        = vt[i].seq;
      expect_at(vt[i].name, cyc, vt[i].en, vt[i].run, vt[i].lk, vt[i].fc, vt[i].rc);
    end
    vt.delete();
  endtask

  initial begin
    int unsigned r, r2, t;
    reset = 1'b1; power_request = 1'b0; seq_up = 1'b0; dsp_heartbeat = 1'b0;

    // Power-on hold, then STARTING entered at r+101 and seq_up seen 50 ticks in.
    do_reset(1'b1, 1'b0, r);
    expect_at("reset_state",  r,       0, 0, 0, 2'd0, 2'd0);
    expect_at("por_hold_mid", r + 50,  0, 0, 0, 2'd0, 2'd0);
    expect_at("por_hold_end", r + 101, 0, 0, 0, 2'd0, 2'd0);
    expect_at("enable_rise",  r + 102, 1, 0, 0, 2'd0, 2'd0);
    step_to(r + 151);
    seq_up = 1'b1;
    expect_at("run_pre",  r + 154, 1, 0, 0, 2'd0, 2'd0);
    expect_at("run_rise", r + 155, 1, 1, 0, 2'd0, 2'd0);
    step_to(r + 160);

    // Four start timeouts: backoffs 500/1000/2000, then lockout and release.
    do_reset(1'b1, 1'b0, r);
    add_vec("lk_reset",     0,    1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_vec("lk_por",       101,  1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_vec("lk_en1",       102,  1, 0, 1, 0, 0, 2'd0, 2'd0);
    add_vec("to1_pre",      1101, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    add_vec("to1_fault",    1102, 1, 0, 0, 0, 0, 2'd1, 2'd0);
    add_vec("to1_minoff",   1401, 1, 0, 0, 0, 0, 2'd1, 2'd0);
    add_vec("bo500_end",    1901, 1, 0, 0, 0, 0, 2'd1, 2'd0);
    add_vec("bo500_restart",1902, 1, 0, 1, 0, 0, 2'd1, 2'd1);
    add_vec("to2_pre",      2901, 1, 0, 1, 0, 0, 2'd1, 2'd1);
    add_vec("to2_fault",    2902, 1, 0, 0, 0, 0, 2'd1, 2'd1);
    add_vec("bo1000_end",   4201, 1, 0, 0, 0, 0, 2'd1, 2'd1);
    add_vec("bo1000_rst",   4202, 1, 0, 1, 0, 0, 2'd1, 2'd2);
    add_vec("to3_pre",      5201, 1, 0, 1, 0, 0, 2'd1, 2'd2);
    add_vec("to3_fault",    5202, 1, 0, 0, 0, 0, 2'd1, 2'd2);
    add_vec("bo2000_end",   7501, 1, 0, 0, 0, 0, 2'd1, 2'd2);
    add_vec("bo2000_rst",   7502, 1, 0, 1, 0, 0, 2'd1, 2'd3);
    add_vec("to4_pre",      8501, 1, 0, 1, 0, 0, 2'd1, 2'd3);
    add_vec("to4_fault",    8502, 1, 0, 0, 0, 0, 2'd1, 2'd3);
    add_vec("lockout_pre",  8801, 1, 0, 0, 0, 0, 2'd1, 2'd3);
    add_vec("lockout",      8802, 1, 0, 0, 0, 1, 2'd1, 2'd3);
    add_vec("lk_req_low",   8900, 0, 0, 0, 0, 1, 2'd1, 2'd3);
    add_vec("lk_req_back",  8901, 1, 0, 0, 0, 1, 2'd1, 2'd3);
    add_vec("lk_cleared",   8902, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    add_vec("lk_restart",   8903, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    run_vectors(r);

    // seq_up dropout with power_request falling on the fault cycle.
    do_reset(1'b1, 1'b1, r);
    add_vec("dr_reset",     0,    1, 1, 0, 0, 0, 2'd0, 2'd0);
    add_vec("dr_en",        102,  1, 1, 1, 0, 0, 2'd0, 2'd0);
    add_vec("dr_run",       103,  1, 1, 1, 1, 0, 2'd0, 2'd0);
    add_vec("dr_seq_low",   200,  1, 0, 1, 1, 0, 2'd0, 2'd0);
    add_vec("dr_req_low",   202,  0, 0, 1, 1, 0, 2'd0, 2'd0);
    add_vec("dr_pre",       203,  0, 0, 1, 1, 0, 2'd0, 2'd0);
    add_vec("dr_fault",     204,  0, 0, 0, 0, 0, 2'd2, 2'd0);
    add_vec("dr_bo_end",    1003, 0, 0, 0, 0, 0, 2'd2, 2'd0);
    add_vec("dr_off_rc",    1004, 0, 0, 0, 0, 0, 2'd2, 2'd1);
    add_vec("dr_stay_off",  1100, 0, 0, 0, 0, 0, 2'd2, 2'd1);
    run_vectors(r);

    // Reach retry_count=2, run stably with heartbeat, then reset mid-RUNNING.
    do_reset(1'b1, 1'b0, r);
    expect_at("st_bo_end",   r + 4201,  0, 0, 0, 2'd1, 2'd1);
    expect_at("st_rc2",      r + 4202,  1, 0, 0, 2'd1, 2'd2);
    expect_at("st_run_pre",  r + 4303,  1, 0, 0, 2'd1, 2'd2);
    expect_at("st_run",      r + 4304,  1, 1, 0, 2'd1, 2'd2);
    expect_at("stable_pre",  r + 14303, 1, 1, 0, 2'd1, 2'd2);
    expect_at("stable_clr",  r + 14304, 1, 1, 0, 2'd0, 2'd0);
    step_to(r + 4300);
    seq_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_to(r + 4300 + 1000 * i);
      dsp_heartbeat = ~dsp_heartbeat;
    end
    step_to(r + 16400);
    expect_at("pre_reset", cyc, 1, 1, 0, 2'd0, 2'd0);
    reset = 1'b1;
    step_to(cyc + 1);
    expect_at("reset_midrun", cyc, 0, 0, 0, 2'd0, 2'd0);
    reset = 1'b0;
    r2 = cyc;
    expect_at("repor_mid",  r2 + 50,  0, 0, 0, 2'd0, 2'd0);
    expect_at("repor_end",  r2 + 101, 0, 0, 0, 2'd0, 2'd0);
    expect_at("repor_en",   r2 + 102, 1, 0, 0, 2'd0, 2'd0);
    expect_at("repor_run",  r2 + 103, 1, 1, 0, 2'd0, 2'd0);
    step_to(r2 + 110);

    // Heartbeat stops: watchdog fault 5000 after the last edge; then no heartbeat at all: 20000.
    do_reset(1'b1, 1'b1, r);
    t = r + 5200;
    expect_at("hb_run",       r + 103,    1, 1, 0, 2'd0, 2'd0);
    expect_at("hb_mid",       r + 4000,   1, 1, 0, 2'd0, 2'd0);
    expect_at("wdt_pre",      t + 5003,   1, 1, 0, 2'd0, 2'd0);
    expect_at("wdt_fault",    t + 5004,   0, 0, 0, 2'd3, 2'd0);
    expect_at("wdt_bo_end",   t + 5803,   0, 0, 0, 2'd3, 2'd0);
    expect_at("wdt_restart",  t + 5804,   1, 0, 0, 2'd3, 2'd1);
    expect_at("wdt_rerun",    t + 5805,   1, 1, 0, 2'd3, 2'd1);
    expect_at("grace_stable", t + 15804,  1, 1, 0, 2'd3, 2'd1);
    expect_at("grace_clr",    t + 15805,  1, 1, 0, 2'd0, 2'd0);
    expect_at("grace_pre",    t + 25804,  1, 1, 0, 2'd0, 2'd0);
    expect_at("grace_fault",  t + 25805,  0, 0, 0, 2'd3, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step_to(r + 200 + 1000 * i);
      dsp_heartbeat = ~dsp_heartbeat;
    end
    step_to(t + 25810);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c66x_power_supervisor.md
Name: c66x_power_supervisor

Overview:
- Initiator side of the C66x power-sequencer handshake. Decides when the sequencer `enable` is asserted and judges from sequencer/DSP status whether the DSP came up and stays healthy.
- Applies the CPLD power-on hold, start timeout, DSP heartbeat watchdog, minimum off time, exponential retry backoff and fault lockout.
- Sits between host/switch power request and the sequencer, in the same sysclk (100us tick) domain.

Parameters:
- POR_DELAY, 100, ticks after reset before any enable (10ms).
- START_TIMEOUT, 1000, max ticks in STARTING for seq_up to be seen (100ms).
- BOOT_GRACE, 20000, ticks after entering RUNNING before the first heartbeat is required (2s).
- WDT_TIMEOUT, 5000, max ticks between heartbeat rising edges once armed (500ms).
- MIN_OFF, 300, ticks enable held low in STOPPING (30ms; covers the sequencer's 25ms off hold).
- BACKOFF_BASE, 500, base backoff ticks; actual = BACKOFF_BASE << retry_count.
- MAX_RETRIES, 3, faults tolerated before lockout (max 3).
- STABLE_TIME, 10000, RUNNING ticks after which retry_count clears.

Ports:
- sysclk  in  1  system clock, 100us tick.
- reset  in  1  synchronous, active-high reset.
- power_request  in  1  host/switch request for DSP power; level.
- seq_up  in  1  asynchronous; high when the sequencer has released resetfull_INV.
- dsp_heartbeat  in  1  asynchronous DSP GPIO toggle.
- enable  out  1  registered; drives sequencer enable.
- running  out  1  registered; high in RUNNING.
- lockout  out  1  registered; high in LOCKOUT.
- fault_code  out  2  registered; 0 none, 1 start timeout, 2 seq dropout, 3 watchdog.
- retry_count  out  2  registered; faults since last stable run.

Behaviour:
- Reset value of all outputs is 0. On reset the state is POR_HOLD and the timers are cleared. Reset mid-operation drops enable the next cycle, with no STOPPING hold.
- seq_up and dsp_heartbeat each pass through a 2-flop synchroniser. A heartbeat edge is a rising edge of the synchronised signal, so input-to-effect latency is 3 cycles.
- Timer: 16-bit, cleared on every state change, otherwise +1 and saturating at 0xFFFF. The watchdog counter is separate, 16-bit, and cleared on each heartbeat edge.
- All outputs are registered: changes appear 1 cycle after the state transition.
- States and transitions:
  - POR_HOLD: enable=0. Go to OFF when timer == POR_DELAY-1.
  - OFF: enable=0. Go to STARTING if power_request.
  - STARTING: enable=1.
    - If power_request is low, go to STOPPING with no fault.
    - Else if sync seq_up, go to RUNNING.
    - Else if timer == START_TIMEOUT-1, set fault 1 and go to STOPPING.
  - RUNNING: enable=1, running=1. Checks in priority order:
    1. sync seq_up low: fault 2, go to STOPPING.
    2. Watchdog expiry: fault 3, go to STOPPING. The watchdog is unarmed until the first heartbeat edge. Unarmed, it expires at BOOT_GRACE; armed, it expires at WDT_TIMEOUT.
    3. power_request low: go to STOPPING with no fault.
    4. timer == STABLE_TIME-1: clear retry_count and fault_code, stay in RUNNING.
  - STOPPING: enable=0. When timer == MIN_OFF-1:
    - no fault pending: go to OFF;
    - fault pending and retry_count == MAX_RETRIES: go to LOCKOUT;
    - otherwise: go to BACKOFF.
  - BACKOFF: enable=0. When timer == (BACKOFF_BASE << retry_count)-1, increment retry_count, then go to STARTING if power_request, else OFF.
  - LOCKOUT: enable=0, lockout=1. Leave only when power_request is seen low. On leaving, go to OFF and clear retry_count and fault_code.
- A fault and a power_request drop in the same cycle record the fault; the fault has priority.
- fault_code holds the most recent fault until it is cleared by a stable run or by leaving LOCKOUT. A new fault overwrites it.
- retry_count saturates at 3. The backoff shift is computed in 16 bits; the maximum is 4000 ticks.
- Any unused state encoding goes to STOPPING with enable=0.

Test Plan:
- Reset, power_request=1 held -> enable stays 0 for 100 ticks, rises 1 cycle after the OFF→STARTING transition; seq_up at tick 50 of STARTING -> running=1 at about tick 54.
- STARTING with seq_up never high -> fault_code=1 at tick 1000, enable=0 for 300 ticks, BACKOFF of 500 ticks, retry_count=1, enable reasserts.
- RUNNING with heartbeat toggling every 1000 ticks, then stopped -> after the last edge, fault_code=3 at 5000 ticks and enable drops; with no heartbeat at all, fault at 20000 ticks.
- Four consecutive start timeouts -> backoffs of 500, 1000 and 2000 ticks, then LOCKOUT with lockout=1 and retry_count=3; power_request low for 1 cycle -> OFF with fault_code=0 and retry_count=0.
- RUNNING with seq_up dropped for 3+ cycles -> fault_code=2; power_request dropped in the same cycle -> fault still recorded and the path goes STOPPING→BACKOFF→OFF.
- retry_count=2, then RUNNING for 10000 ticks with a healthy heartbeat -> retry_count=0 and fault_code=0; reset asserted mid-RUNNING -> enable=0 the next cycle and the state returns to POR_HOLD.
